// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel-rate divider, h/v counters,
// visible-region flag, registered colour/sync pin stage, and a per-frame
// strobe with a wrapping frame counter used as the game-update timebase.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 784,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 515
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  input  logic [11:0] rgb_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hSync,
  output logic        vSync,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  // A divide-by-one still needs a one-bit register so the widths stay legal.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_DISP_START);
  localparam logic [9:0] H_VIS_HI = 10'(H_DISP_END);
  localparam logic [9:0] V_VIS_LO = 10'(V_DISP_START);
  localparam logic [9:0] V_VIS_HI = 10'(V_DISP_END);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             tick_q, tick_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             line_end;
  logic             frame_end;

  // Pixel strobe from the divider; gated by rst so it is never seen while held in reset.
  always_comb begin
    pix_en    = rst && (div_q == DIV_LAST);
    line_end  = (h_q == H_LAST);
    frame_end = pix_en && line_end && (v_q == V_LAST);
    bright    = (h_q >= H_VIS_LO) && (h_q < H_VIS_HI) &&
                (v_q >= V_VIS_LO) && (v_q < V_VIS_HI);
  end

  // Next-state for divider, raster counters, pin stage and frame strobe.
  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    tick_d  = frame_end;
    fcnt_d  = frame_end ? fcnt_q + 16'd1 : fcnt_q;
    if (pix_en) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Pins carry the pixel the counters showed during this pixel period.
      rgb_d   = bright ? rgb_in : 12'h000;
      hsync_d = !(h_q < H_SYNC_W);
      vsync_d = !(v_q < V_SYNC_W);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign hCount      = h_q;
  assign vCount      = v_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign frame_tick  = tick_q;
  assign frame_count = fcnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 640x480@60 raster timing that the pixel-colour blocks (game/block controllers) consume: hCount, vCount, bright.
- Registers the returned 12-bit colour and drives the VGA pins, with hSync/vSync delayed so they stay aligned with the colour.
- Provides a once-per-frame strobe and a frame counter, which serve as the slow game-update timebase.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 1.
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, hSync low width in pixels.
- H_DISP_START, 144, first visible hCount.
- H_DISP_END, 784, first non-visible hCount after the active region.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines.
- V_DISP_START, 35, first visible vCount.
- V_DISP_END, 515, first non-visible vCount after the active region.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low: asserted when 0, sampled on the rising edge of clk.
- pix_en  out  1  one-clk pulse; every counter and pipeline register advances only when it is 1.
- hCount  out  10  current pixel column, 0..H_TOTAL-1.
- vCount  out  10  current line, 0..V_TOTAL-1.
- bright  out  1  combinational: current hCount/vCount lie in the visible region.
- rgb_in  in  12  colour for the current hCount/vCount, {R[3:0],G[3:0],B[3:0]}, returned combinationally by the colour block.
- vga_r, vga_g, vga_b  out  4 each  registered colour to the pins.
- hSync  out  1  registered, active-low, aligned with vga_*.
- vSync  out  1  registered, active-low, aligned with vga_*.
- frame_tick  out  1  one-clk pulse at the end of each frame.
- frame_count  out  16  frames completed since reset, wraps.

Behaviour:
Reset (rst=0 at a clk edge):
- Next cycle: div=0, hCount=0, vCount=0, pix_en=0, vga_r/g/b=0, hSync=1, vSync=1, frame_tick=0, frame_count=0.
- Reset takes effect regardless of position in the line or frame; there is no partial-line completion.

Pixel divider:
- div counts 0..CLK_DIV-1 and wraps.
- pix_en=1 exactly in the cycle where div==CLK_DIV-1.
- With CLK_DIV=1, pix_en is constantly 1 after reset.
- pix_en is combinational from div; it is 0 during reset.

Counters (update on the clk edge where pix_en=1):
- hCount==H_TOTAL-1: hCount<=0 and vCount advances. Otherwise hCount<=hCount+1.
- vCount advance: vCount==V_TOTAL-1 -> 0, else +1.
- No other increment path exists.

bright:
- bright = (H_DISP_START<=hCount<H_DISP_END) && (V_DISP_START<=vCount<V_DISP_END).
- Purely combinational from the counter registers, so colour blocks see hCount, vCount and bright coherently within one pixel.

Output stage (one-pixel latency, updates only when pix_en=1):
- {vga_r,vga_g,vga_b} <= bright ? rgb_in : 0. Blanking is forced here regardless of rgb_in.
- hSync <= ~(hCount < H_SYNC).
- vSync <= ~(vCount < V_SYNC).
- Pin outputs for pixel (h,v) therefore appear one pixel period after the counters show (h,v).

Frame strobe:
- frame_tick=1 for exactly one clk when pix_en=1 and hCount==H_TOTAL-1 and vCount==V_TOTAL-1, i.e. the same edge the counters wrap to (0,0).
- frame_count increments on that same edge; 0xFFFF wraps to 0.

General:
- Outputs hold between pix_en pulses.
- No input other than rst alters timing; rgb_in only affects vga_*.

Test Plan:
Simulations 1-4 use default parameters; 5-6 use reduced values (H_TOTAL=10, H_SYNC=2, H_DISP 3..8, V_TOTAL=6, V_SYNC=1, V_DISP 2..5).
1. rst=0 for 3 clks, then 1 -> all outputs at reset values; pix_en first high on clk 4 after release; hCount=1 after that edge; pix_en period 4 clks.
2. Run 800 pix_en -> hCount 799->0 and vCount 0->1 on the same edge; no frame_tick.
3. Measure hSync -> low for 384 clks, period 3200 clks, falling edge one pixel (4 clks) after hCount becomes 0. vSync low for 2 lines (6400 clks) per 1,680,000-clk frame.
4. rgb_in=12'hF0F constant, vCount=100 -> vga_*=0 while the output pixel is hCount 143; F/0/F for pixels 144..783; 0 again from 784, each edge delayed one pixel.
5. Reduced parameters -> frame_tick every 60 pix_en (240 clks), one clk wide, coincident with the (9,5)->(0,0) wrap. After 65536 frames, frame_count returns to 0.
6. Assert rst=0 for one clk mid-frame at hCount=400, vCount=200 (defaults) -> next cycle hCount=vCount=0, frame_count=0, hSync=vSync=1, vga_*=0; timing restarts exactly as in scenario 1.
